// File: rtl/matrix_cmd_sequencer.sv
// Command sequencer for the matrix ALU: owns A/B operands and result C, one response per command.
// LOAD/READ/reject respond the cycle after accept; EXEC responds after ALU capture; busy until rsp handshake.
module matrix_cmd_sequencer #(
  parameter int ARITH_WAIT   = 1,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [2:0]   cmd_row,
  input  logic [39:0]  cmd_data,
  input  logic [2:0]   cmd_alu_op,
  input  logic [2:0]   cmd_size,
  input  logic [7:0]   cmd_scalar,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [39:0]  rsp_data,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic [199:0] alu_a_flat,
  output logic [199:0] alu_b_flat,
  output logic [2:0]   alu_opcode,
  output logic [7:0]   alu_scalar,
  output logic [2:0]   alu_matrix_size,
  input  logic [199:0] alu_c_flat,
  input  logic [7:0]   alu_number,
  input  logic         alu_overflow,
  input  logic         alu_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  localparam int CNT_MAX = (DONE_TIMEOUT > ARITH_WAIT) ? DONE_TIMEOUT : ARITH_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_LOAD_B = 2'b01;
  localparam logic [1:0] OP_EXEC   = 2'b10;
  localparam logic [2:0] ALU_DET   = 3'b111;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    op_q;
  logic [199:0]  c_q;
  logic [7:0]    row_base;
  logic          row_bad;
  logic          exec_bad;
  logic          is_det;

  // row*40 built from shifts so the select index is exactly 8 bits wide
  assign row_base = {cmd_row, 5'b0} + {2'b0, cmd_row, 3'b0};
  assign row_bad  = (cmd_row > 3'd4);
  assign exec_bad = (cmd_alu_op == 3'b000) ||
                    ((cmd_alu_op == ALU_DET) && ((cmd_size < 3'd2) || (cmd_size > 3'd5)));
  assign is_det   = (op_q == ALU_DET);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cmd_ready       <= 1'b0;
      wait_cnt        <= '0;
      op_q            <= 3'b000;
      c_q             <= '0;
      alu_a_flat      <= '0;
      alu_b_flat      <= '0;
      alu_opcode      <= 3'b000;
      alu_scalar      <= 8'h00;
      alu_matrix_size <= 3'b000;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_ovf         <= 1'b0;
      rsp_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
            case (cmd_op)
              OP_LOAD_A, OP_LOAD_B: begin
                if (row_bad) begin
                  rsp_err <= 1'b1;
                end else if (cmd_op == OP_LOAD_A) begin
                  alu_a_flat[row_base +: 40] <= cmd_data;
                end else begin
                  alu_b_flat[row_base +: 40] <= cmd_data;
                end
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              OP_EXEC: begin
                if (exec_bad) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
                end else begin
                  op_q            <= cmd_alu_op;
                  alu_opcode      <= cmd_alu_op;
                  alu_scalar      <= cmd_scalar;
                  alu_matrix_size <= cmd_size;
                  state           <= ISSUE;
                end
              end
              default: begin
                if (row_bad) begin
                  rsp_err <= 1'b1;
                end else begin
                  rsp_data <= c_q[row_base +: 40];
                end
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
            endcase
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (is_det) begin
            // done is checked before the timeout so a done on the last cycle still wins
            if (alu_done) begin
              state <= CAPTURE;
            end else if (wait_cnt == CW'(DONE_TIMEOUT)) begin
              alu_opcode <= 3'b000;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (wait_cnt == CW'(ARITH_WAIT - 1)) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          alu_opcode <= 3'b000;
          rsp_ovf    <= alu_overflow;
          if (is_det) begin
            rsp_data <= {32'b0, alu_number};
          end else begin
            c_q <= alu_c_flat;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_cmd_sequencer.sv
// Bench for matrix_cmd_sequencer with a behavioural ALU and a response scoreboard.
module tb_matrix_cmd_sequencer;
  localparam int ARITH_WAIT   = 1;
  localparam int DONE_TIMEOUT = 64;

  localparam logic [1:0] LOAD_A = 2'b00;
  localparam logic [1:0] LOAD_B = 2'b01;
  localparam logic [1:0] EXEC   = 2'b10;
  localparam logic [1:0] READ_C = 2'b11;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [2:0]   cmd_row = '0;
  logic [39:0]  cmd_data = '0;
  logic [2:0]   cmd_alu_op = '0;
  logic [2:0]   cmd_size = '0;
  logic [7:0]   cmd_scalar = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [39:0]  rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;
  logic [199:0] alu_a_flat;
  logic [199:0] alu_b_flat;
  logic [2:0]   alu_opcode;
  logic [7:0]   alu_scalar;
  logic [2:0]   alu_matrix_size;
  logic [199:0] alu_c_flat;
  logic [7:0]   alu_number;
  logic         alu_overflow;
  logic         alu_done;

  typedef struct packed {
    logic [39:0] data;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic done_en = 1'b0;
  int   det_cyc = 0;

  matrix_cmd_sequencer #(.ARITH_WAIT(ARITH_WAIT), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
    .cmd_data(cmd_data), .cmd_alu_op(cmd_alu_op), .cmd_size(cmd_size), .cmd_scalar(cmd_scalar),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .rsp_err(rsp_err), .alu_a_flat(alu_a_flat), .alu_b_flat(alu_b_flat), .alu_opcode(alu_opcode),
    .alu_scalar(alu_scalar), .alu_matrix_size(alu_matrix_size), .alu_c_flat(alu_c_flat),
    .alu_number(alu_number), .alu_overflow(alu_overflow), .alu_done(alu_done)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: element-wise signed ops with 8-bit overflow, 2x2 determinant after 3 cycles
  function automatic logic [7:0] el(input logic [199:0] m, input int r, input int c);
    return m[r*40 + c*8 +: 8];
  endfunction

  function automatic logic [200:0] alu_model(input logic [2:0] op, input logic [199:0] a,
                                             input logic [199:0] b, input logic [7:0] s);
    logic [199:0] c;
    logic         ovf;
    int           x;
    c   = '0;
    ovf = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        case (op)
          3'b001:  x = int'($signed(el(a, r, k))) + int'($signed(el(b, r, k)));
          3'b010:  x = int'($signed(el(a, r, k))) - int'($signed(el(b, r, k)));
          3'b100:  x = -int'($signed(el(a, r, k)));
          3'b101:  x = int'($signed(el(a, k, r)));
          3'b110:  x = int'($signed(el(a, r, k))) * int'($signed(s));
          default: x = 0;
        endcase
        if (x > 127 || x < -128) ovf = 1'b1;
        c[r*40 + k*8 +: 8] = x[7:0];
      end
    end
    return {ovf, c};
  endfunction

  function automatic logic [7:0] det2(input logic [199:0] a);
    int p;
    p = int'($signed(el(a, 0, 0))) * int'($signed(el(a, 1, 1)))
      - int'($signed(el(a, 0, 1))) * int'($signed(el(a, 1, 0)));
    return p[7:0];
  endfunction

  assign {alu_overflow, alu_c_flat} = alu_model(alu_opcode, alu_a_flat, alu_b_flat, alu_scalar);
  assign alu_number = det2(alu_a_flat);
  assign alu_done   = done_en && (det_cyc >= 3);

  always @(posedge clock) begin
    if (alu_opcode == 3'b111) det_cyc <= det_cyc + 1;
    else det_cyc <= 0;
  end

  // Response monitor: the handshake completes on the following rising edge
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got data=%h err=%b, required no response", rsp_data, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (rsp_data !== mon_e.data) begin
          errors++; $display("FAIL rsp_data: got %h required %h", rsp_data, mon_e.data);
        end
        checks++;
        if (rsp_ovf !== mon_e.ovf) begin
          errors++; $display("FAIL rsp_ovf: got %b required %b", rsp_ovf, mon_e.ovf);
        end
        checks++;
        if (rsp_err !== mon_e.err) begin
          errors++; $display("FAIL rsp_err: got %b required %b", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // lat: rising edges after the accept edge until rsp_valid; -1 no response, -2 never accepted
  task automatic start_cmd(input logic [1:0] op, input logic [2:0] row, input logic [39:0] data,
                           input logic [2:0] aop, input logic [2:0] size, input logic [7:0] scal,
                           input logic [39:0] e_data, input logic e_ovf, input logic e_err,
                           output int lat);
    int guard;
    cmd_op = op; cmd_row = row; cmd_data = data;
    cmd_alu_op = aop; cmd_size = size; cmd_scalar = scal;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      tick(); guard++;
    end
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      lat = -2;
      return;
    end
    sb.push_back({e_data, e_ovf, e_err});
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < DONE_TIMEOUT + 20) begin
      tick(); lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic finish_rsp();
    if (rsp_valid === 1'b1) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] row, input logic [39:0] data,
                        input logic [2:0] aop, input logic [2:0] size, input logic [7:0] scal,
                        input logic [39:0] e_data, input logic e_ovf, input logic e_err,
                        output int lat);
    start_cmd(op, row, data, aop, size, scal, e_data, e_ovf, e_err, lat);
    finish_rsp();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode: got %b required 000", alu_opcode); end
    checks++; if (alu_a_flat !== '0 || alu_b_flat !== '0) begin errors++; $display("FAIL reset_operands: got nonzero required 0"); end
    checks++; if (alu_matrix_size !== 3'd0 || alu_scalar !== 8'd0) begin errors++; $display("FAIL reset_size_scalar: got %0d/%0d required 0/0", alu_matrix_size, alu_scalar); end
    checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b/%b required 0", rsp_data, rsp_ovf, rsp_err); end
    reset_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_bad_row();
    int lat;
    do_cmd(LOAD_A, 3'd5, {40{1'b1}}, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b1, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL bad_row_lat: got %0d required 0", lat); end
    checks++; if (alu_a_flat !== '0) begin errors++; $display("FAIL bad_row_a: got %h required 0", alu_a_flat); end
    do_cmd(EXEC, 3'd0, 40'h0, 3'b100, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    checks++; if (lat !== ARITH_WAIT + 2) begin errors++; $display("FAIL neg_lat: got %0d required %0d", lat, ARITH_WAIT + 2); end
    for (int r = 0; r < 5; r++) do_cmd(READ_C, 3'(r), 40'h0, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    do_cmd(READ_C, 3'd7, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b1, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL read_bad_lat: got %0d required 0", lat); end
  endtask

  task automatic test_det();
    int lat;
    done_en = 1'b1;
    do_cmd(LOAD_A, 3'd0, 40'h0000000201, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    do_cmd(LOAD_A, 3'd1, 40'h0000000403, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    do_cmd(EXEC, 3'd0, 40'h0, 3'b111, 3'd2, 8'd0, 40'h00000000FE, 1'b0, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL det_lat: got %0d required 5", lat); end
    checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL det_opcode_after: got %b required 000", alu_opcode); end
    checks++; if (alu_matrix_size !== 3'd2) begin errors++; $display("FAIL det_size: got %0d required 2", alu_matrix_size); end
    done_en = 1'b0;
  endtask

  task automatic test_arith();
    int lat;
    do_cmd(LOAD_A, 3'd0, 40'h64, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    do_cmd(LOAD_B, 3'd0, 40'h64, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL load_b_lat: got %0d required 0", lat); end
    do_cmd(EXEC, 3'd0, 40'h0, 3'b001, 3'd0, 8'd0, 40'h0, 1'b1, 1'b0, lat);
    checks++; if (lat !== ARITH_WAIT + 2) begin errors++; $display("FAIL add_lat: got %0d required %0d", lat, ARITH_WAIT + 2); end
    do_cmd(READ_C, 3'd0, 40'h0, 3'd0, 3'd0, 8'd0, 40'h00000000C8, 1'b0, 1'b0, lat);
    do_cmd(READ_C, 3'd1, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0000000403, 1'b0, 1'b0, lat);
    do_cmd(EXEC, 3'd0, 40'h0, 3'b110, 3'd0, 8'd3, 40'h0, 1'b1, 1'b0, lat);
    checks++; if (alu_scalar !== 8'd3) begin errors++; $display("FAIL scalar_latch: got %0d required 3", alu_scalar); end
    checks++; if (alu_a_flat[79:0] !== 80'h0000000403_0000000064) begin errors++; $display("FAIL a_unchanged: got %h", alu_a_flat[79:0]); end
    do_cmd(READ_C, 3'd0, 40'h0, 3'd0, 3'd0, 8'd0, 40'h000000002C, 1'b0, 1'b0, lat);
    do_cmd(READ_C, 3'd1, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0000000C09, 1'b0, 1'b0, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    start_cmd(READ_C, 3'd1, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0000000C09, 1'b0, 1'b0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL bp_lat: got %0d required 0", lat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 40'h0000000C09 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b required 1/0000000c09/0", i, rsp_valid, rsp_data, cmd_ready);
      end
    end
    finish_rsp();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b required 1", cmd_ready); end
  endtask

  task automatic test_timeout();
    int lat;
    do_cmd(EXEC, 3'd0, 40'h0, 3'b111, 3'd2, 8'd0, 40'h0, 1'b0, 1'b1, lat);
    checks++; if (lat !== DONE_TIMEOUT + 2) begin errors++; $display("FAIL timeout_lat: got %0d required %0d", lat, DONE_TIMEOUT + 2); end
    checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL timeout_opcode: got %b required 000", alu_opcode); end
    do_cmd(EXEC, 3'd0, 40'h0, 3'b111, 3'd6, 8'd0, 40'h0, 1'b0, 1'b1, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL det_size6_lat: got %0d required 0", lat); end
    do_cmd(EXEC, 3'd0, 40'h0, 3'b000, 3'd2, 8'd0, 40'h0, 1'b0, 1'b1, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL op0_lat: got %0d required 0", lat); end
    do_cmd(READ_C, 3'd1, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0000000C09, 1'b0, 1'b0, lat);
  endtask

  task automatic test_mid_reset();
    int lat;
    int guard;
    cmd_op = EXEC; cmd_row = 3'd0; cmd_alu_op = 3'b111; cmd_size = 3'd2; cmd_scalar = 8'd0;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (alu_opcode !== 3'b111) begin errors++; $display("FAIL wait_opcode: got %b required 111", alu_opcode); end
    reset_n = 1'b0;
    #1;
    checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL mid_reset_opcode: got %b required 000", alu_opcode); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_hs: got valid=%b ready=%b required 0/0", rsp_valid, cmd_ready); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b required 1", cmd_ready); end
    do_cmd(READ_C, 3'd0, 40'h0, 3'd0, 3'd0, 8'd0, 40'h0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL mid_reset_read_lat: got %0d required 0", lat); end
  endtask

  initial begin
    test_reset();
    test_bad_row();
    test_det();
    test_arith();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
